dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the memory-side end of the core's data port, with a valid/ready handshake.
//  Accepts one load/store request at a time and holds it for a configurable access latency.
//  Returns a read-data or error response, which models a multi-cycle memory behind the core.
//  Sits where the combinational dmem sits today. Lets the core's stall logic be exercised.
// PARAMETERS
//  ADDR_W      32    request address width (bytes)
//  DATA_W      64    data word width; byte strobe width = DATA_W/8
//  DEPTH_WORDS 1024  number of DATA_W words in storage (power of 2)
//  LATENCY     2     wait cycles between accept and response (0..15)
// PORTS
//  clk         in   1        clock, rising edge
//  reset       in   1        asynchronous, active-low reset
//  req_valid   in   1        request present
//  req_ready   out  1        responder can accept a request
//  req_addr    in   ADDR_W   byte address
//  req_we      in   1        1 = store, 0 = load
//  req_strobe  in   DATA_W/8 byte-enable mask for stores
//  req_wdata   in   DATA_W   store data
//  resp_valid  out  1        response present
//  resp_ready  in   1        core takes the response
//  resp_rdata  out  DATA_W   load data (0 for stores and for errors)
//  resp_err    out  1        misaligned or out-of-range access
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE. req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
//   Storage array is not cleared.
//  FSM states IDLE, WAIT, RESP. req_ready=1 only in IDLE. resp_valid=1 only in RESP.
//  IDLE: on req_valid at a clk edge, latch addr/we/strobe/wdata and load counter=LATENCY.
//   If LATENCY=0, go to RESP. Otherwise go to WAIT.
//  WAIT: decrement the counter each cycle. When counter==1, perform the access and go to RESP.
//   Accept->resp_valid latency is therefore LATENCY+1 cycles.
//  Access (performed on the edge entering RESP):
//   err = (addr[2:0]!=0) or (addr>>3 >= DEPTH_WORDS). Word index = addr[3 +: log2(DEPTH_WORDS)].
//   Load, no err: resp_rdata <= mem[idx].
//   Store, no err: update each byte b of mem[idx] where strobe[b]=1. resp_rdata <= 0.
//   Store with strobe=0 is legal: no change, normal response.
//   Any err: no memory change, resp_rdata <= 0, resp_err <= 1.
//  RESP: hold resp_valid, resp_rdata and resp_err stable until resp_ready=1.
//   On the handshake edge, return to IDLE and clear resp_valid and resp_err. req_ready=1 the next cycle.
//   A request is never accepted in the same cycle as a response handshake (no back-to-back overlap).
//  Request inputs are ignored outside IDLE. The latched copy is used.
//  Ordering: strictly one outstanding transaction. A load after a store to the same word sees the stored data.
//  Reset mid-operation: transaction abandoned. A store still in WAIT is not committed.
//   A store already in RESP stays committed.
//  Counter width is 4 bits. LATENCY>15 is illegal (elaboration assertion).
// TESTING
//  1 LATENCY=2: store 0x1122334455667788 to 0x80, strobe 0xFF. Then load 0x80.
//    -> resp_valid 3 cycles after accept, rdata=0x1122334455667788, err=0.
//  2 Partial store of 0xAAAA...AA, strobe 0x0F, to the word from test 1. Then load.
//    -> rdata=0x11223344AAAAAAAA.
//  3 Load from 0x84 (misaligned) and from 0x2000 (out of range, DEPTH_WORDS=1024).
//    -> err=1, rdata=0, memory unchanged.
//  4 Hold resp_ready=0 for 5 cycles in RESP.
//    -> resp_valid/rdata stable, req_ready=0, new req_valid ignored.
//  5 Assert reset low while a store is in WAIT, then load the same address.
//    -> old data returned. Outputs reach reset values asynchronously.
//  6 LATENCY=0 build: load -> resp_valid on the cycle after accept. Back-to-back traffic alternates accept/respond.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory model behind a valid/ready request/response port.
// One transaction in flight; the access commits on the edge that enters RESP.
module dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic                i_req_we,
    input  logic [DATA_W/8-1:0] i_req_strobe,
    input  logic [DATA_W-1:0]   i_req_wdata,
    output logic                o_resp_valid,
    input  logic                i_resp_ready,
    output logic [DATA_W-1:0]   o_resp_rdata,
    output logic                o_resp_err
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    if (LATENCY > 15 || LATENCY < 0) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be 0..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              r_state, w_next;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [NB-1:0]       r_strobe;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH_WORDS];

    logic                w_idle, w_accept, w_access, w_err, w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [NB-1:0]       w_strobe;
    logic [DATA_W-1:0]   w_wdata;
    logic [IDX_W-1:0]    w_idx;

    // With LATENCY=0 the access happens on the accept edge, so it must use the live inputs.
    assign w_idle   = r_state == IDLE;
    assign w_accept = w_idle && i_req_valid;
    assign w_access = i_reset && ((w_accept && LATENCY == 0) || (r_state == WAIT && r_cnt == 4'd1));
    assign w_addr   = w_idle ? i_req_addr   : r_addr;
    assign w_we     = w_idle ? i_req_we     : r_we;
    assign w_strobe = w_idle ? i_req_strobe : r_strobe;
    assign w_wdata  = w_idle ? i_req_wdata  : r_wdata;
    assign w_err    = (|w_addr[2:0]) || (|w_addr[ADDR_W-1:3+IDX_W]);
    assign w_idx    = w_addr[3 +: IDX_W];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_req_valid)  w_next = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == 4'd1) w_next = RESP;
            RESP:    if (i_resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready  = r_state == IDLE;
        o_resp_valid = r_state == RESP;
        o_resp_rdata = r_rdata;
        o_resp_err   = r_err;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_strobe <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt    <= 4'(LATENCY);
                r_addr   <= i_req_addr;
                r_we     <= i_req_we;
                r_strobe <= i_req_strobe;
                r_wdata  <= i_req_wdata;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_rdata <= (!w_we && !w_err) ? r_mem[w_idx] : '0;
                r_err   <= w_err;
            end else if (r_state == RESP && i_resp_ready) begin
                r_err <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_access && w_we && !w_err)
            for (int b = 0; b < NB; b++)
                if (w_strobe[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for a LATENCY=2 and a LATENCY=0 responder.
module tb_dmem_responder;
    logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0;
    logic [7:0]  req_strobe = '0;
    logic [63:0] req_wdata = '0;
    logic        rdy2, rdy0, rv2, rv0, er2, er0;
    logic [63:0] rd2, rd0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;
    int          n_err = 0, n_chk = 0;
    logic [64:0] q [$];
    logic [63:0] mdl [int];

    always #5 clk = ~clk;

    assign req_ready  = sel ? rdy0 : rdy2;
    assign resp_valid = sel ? rv0 : rv2;
    assign resp_rdata = sel ? rd0 : rd2;
    assign resp_err   = sel ? er0 : er2;

    dmem_responder #(.LATENCY(2)) u2 (
        .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid & ~sel), .o_req_ready(rdy2),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_strobe(req_strobe), .i_req_wdata(req_wdata),
        .o_resp_valid(rv2), .i_resp_ready(resp_ready & ~sel), .o_resp_rdata(rd2), .o_resp_err(er2));

    dmem_responder #(.LATENCY(0)) u0 (
        .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid & sel), .o_req_ready(rdy0),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_strobe(req_strobe), .i_req_wdata(req_wdata),
        .o_resp_valid(rv0), .i_resp_ready(resp_ready & sel), .o_resp_rdata(rd0), .o_resp_err(er0));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_ready"}, {62'd0, rdy2, rdy0}, 64'd3);
        check({tag, "_resp_valid"}, {62'd0, rv2, rv0}, 64'd0);
        check({tag, "_resp_err"}, {62'd0, er2, er0}, 64'd0);
        check({tag, "_rdata2"}, rd2, 64'd0);
        check({tag, "_rdata0"}, rd0, 64'd0);
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [7:0] strb,
                          input logic [63:0] wd, input bit abort);
        int n, key;
        logic err;
        logic [63:0] w;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("req_ready_before", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_strobe = strb; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = addr ^ 32'h8; req_strobe = ~strb; req_wdata = ~wd;
        if (abort) begin
            rst_n = 1'b0; #1;
            reset_checks("async_reset");
            rst_n = 1'b1;
            return;
        end
        err = (addr[2:0] != 3'd0) || (addr[31:13] != 19'd0);
        key = int'({sel, addr[12:3]});
        if (!we && !err) q.push_back({1'b0, mdl.exists(key) ? mdl[key] : 64'd0});
        else             q.push_back({err, 64'd0});
        if (we && !err) begin
            w = mdl.exists(key) ? mdl[key] : 64'd0;
            for (int b = 0; b < 8; b++) if (strb[b]) w[b*8 +: 8] = wd[b*8 +: 8];
            mdl[key] = w;
        end
        n = 1;
        while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("accept_to_valid", 64'(n), sel ? 64'd1 : 64'd3);
        check("req_ready_busy", {63'd0, req_ready}, 64'd0);
    endtask

    task automatic take_resp(input int hold);
        logic [64:0] e;
        check("sb_nonempty", {63'd0, q.size() > 0}, 64'd1);
        if (q.size() == 0) return;
        e = q.pop_front();
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_strobe = 8'hFF; req_wdata = '1;
            check("hold_valid", {63'd0, resp_valid}, 64'd1);
            check("hold_rdata", resp_rdata, e[63:0]);
            check("hold_req_ready", {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("resp_valid", {63'd0, resp_valid}, 64'd1);
        check("resp_rdata", resp_rdata, e[63:0]);
        check("resp_err", {63'd0, resp_err}, {63'd0, e[64]});
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("post_valid", {63'd0, resp_valid}, 64'd0);
        check("post_err", {63'd0, resp_err}, 64'd0);
        check("post_req_ready", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        #1;
        reset_checks("reset");
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b1, 32'h80, 8'hFF, 64'h1122334455667788, 1'b0); take_resp(0);
        do_req(1'b0, 32'h80, 8'h00, 64'h0, 1'b0); take_resp(0);
        do_req(1'b1, 32'h80, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0); take_resp(0);
        do_req(1'b1, 32'h80, 8'h00, 64'h5555555555555555, 1'b0); take_resp(0);
        do_req(1'b0, 32'h80, 8'h00, 64'h0, 1'b0);
        check("partial_store_word", q[0][63:0], 64'h11223344AAAAAAAA);
        take_resp(0);
        do_req(1'b0, 32'h84, 8'h00, 64'h0, 1'b0); take_resp(0);
        do_req(1'b0, 32'h2000, 8'h00, 64'h0, 1'b0); take_resp(0);
        do_req(1'b1, 32'h2080, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0); take_resp(0);
        do_req(1'b1, 32'h81, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0); take_resp(0);
        do_req(1'b0, 32'h80, 8'h00, 64'h0, 1'b0); take_resp(5);
        do_req(1'b0, 32'h80, 8'h00, 64'h0, 1'b0); take_resp(0);
        do_req(1'b1, 32'h80, 8'hFF, 64'hCAFEF00DCAFEF00D, 1'b1);
        @(posedge clk); #1;
        do_req(1'b0, 32'h80, 8'h00, 64'h0, 1'b0); take_resp(0);
        do_req(1'b1, 32'h88, 8'hFF, 64'h0123456789ABCDEF, 1'b0);
        rst_n = 1'b0; #1; rst_n = 1'b1;
        void'(q.pop_back());
        @(posedge clk); #1;
        do_req(1'b0, 32'h88, 8'h00, 64'h0, 1'b0); take_resp(0);
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 32'h40 + 32'(i * 8), 8'hFF, {32'(i), 32'hA5A5_0000 + 32'(i)}, 1'b0); take_resp(0);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 32'h40 + 32'(i * 8), 8'h00, 64'h0, 1'b0); take_resp(0);
        end
        do_req(1'b0, 32'h43, 8'h00, 64'h0, 1'b0); take_resp(0);
        check("sb_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
